// File: rtl/swipt_bridge_pwm.sv
// Full-bridge PWM generator for the SWIPT transmitter, with dead time on both edges of each high-side pulse.
// New settings are validated into a shadow register and only take effect on a period boundary.
module swipt_bridge_pwm #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 6
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] pulse_in,
    input  logic [DT_W-1:0]  dead_in,
    input  logic             load,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             period_start,
    output logic             SWIPT_OUT0,
    output logic             SWIPT_OUT1,
    output logic             SWIPT_OUT2,
    output logic             SWIPT_OUT3
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POS,
        ST_NEG
    } state_e;

    localparam int         CHK_W     = CNT_W + DT_W + 3;
    localparam logic [3:0] GATE_IDLE = 4'b1100; // {OUT3, OUT2, OUT1, OUT0}: both low sides on

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] pul_q;
    logic [DT_W-1:0]  dead_q;
    logic [CNT_W-1:0] pend_per_q;
    logic [CNT_W-1:0] pend_pul_q;
    logic [DT_W-1:0]  pend_dead_q;
    logic             pend_vld_q;
    logic             ack_dly_q;
    logic             ack_q;
    logic             err_q;
    logic             pstart_q;
    logic [3:0]       gate_q;

    logic [CHK_W-1:0] min_per;
    logic             load_ok;
    logic [CNT_W-1:0] half_hp;
    logic [CNT_W-1:0] half_len;
    logic             half_last;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   dead_ext;
    logic [CNT_W:0]   pul_ext;
    logic [CNT_W:0]   half_ext;
    logic [CNT_W:0]   room;
    logic [CNT_W:0]   eff;
    logic             pulse_en;
    logic             in_lead;
    logic             in_on;
    logic             in_trail;
    logic [3:0]       gate_d;

    // Each half needs room for both dead bands plus at least two cycles of pulse.
    assign min_per = (CHK_W'(dead_in) << 2) + CHK_W'(4);
    assign load_ok = load && (period_in >= CNT_W'(4)) && (CHK_W'(period_in) >= min_per);

    always_comb begin
        half_hp   = per_q >> 1;
        half_len  = (state_q == ST_NEG) ? (per_q - half_hp) : half_hp;
        half_last = (cnt_q == half_len - 1'b1);
        cnt_ext   = {1'b0, cnt_q};
        dead_ext  = (CNT_W + 1)'(dead_q);
        pul_ext   = {1'b0, pul_q};
        half_ext  = {1'b0, half_len};
        room      = (half_ext > dead_ext) ? (half_ext - dead_ext) : '0;
        eff       = (pul_ext < room) ? pul_ext : room;
        pulse_en  = (pul_ext > dead_ext);
        in_lead   = (cnt_ext < dead_ext);
        in_on     = !in_lead && (cnt_ext < eff);
        in_trail  = (cnt_ext >= eff) && (cnt_ext < eff + dead_ext);
        // NOTE: gate_d takes its default before the conditional override, so no latch is inferred.
        gate_d    = GATE_IDLE;
        if ((state_q != ST_IDLE) && pulse_en && (in_lead || in_on || in_trail)) begin
            gate_d = (state_q == ST_POS) ? {2'b10, 1'b0, in_on} : {2'b01, in_on, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            per_q       <= CNT_W'(100);
            pul_q       <= '0;
            dead_q      <= DT_W'(4);
            pend_per_q  <= '0;
            pend_pul_q  <= '0;
            pend_dead_q <= '0;
            pend_vld_q  <= 1'b0;
            ack_dly_q   <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            pstart_q    <= 1'b0;
            gate_q      <= GATE_IDLE;
        end else begin
            // NOTE: non-blocking only; a later assignment in this block intentionally overrides an earlier default.
            gate_q    <= gate_d;
            pstart_q  <= (state_q == ST_POS) && (cnt_q == '0);
            err_q     <= load && !load_ok;
            ack_q     <= ack_dly_q;
            ack_dly_q <= 1'b0;

            if (load_ok) begin
                pend_per_q  <= period_in;
                pend_pul_q  <= pulse_in;
                pend_dead_q <= dead_in;
                pend_vld_q  <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pend_vld_q) begin
                        per_q      <= pend_per_q;
                        pul_q      <= pend_pul_q;
                        dead_q     <= pend_dead_q;
                        pend_vld_q <= load_ok;
                        ack_q      <= 1'b1;
                    end else if (load_ok) begin
                        per_q      <= period_in;
                        pul_q      <= pulse_in;
                        dead_q     <= dead_in;
                        pend_vld_q <= 1'b0;
                        ack_q      <= 1'b1;
                    end
                    if (en) begin
                        state_q <= ST_POS;
                    end
                    cnt_q <= '0;
                end
                ST_POS: begin
                    if (half_last) begin
                        state_q <= ST_NEG;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_NEG: begin
                    if (half_last) begin
                        cnt_q <= '0;
                        if (en) begin
                            state_q <= ST_POS;
                            // The acknowledge is delayed one cycle so it lines up with period_start.
                            if (pend_vld_q) begin
                                per_q      <= pend_per_q;
                                pul_q      <= pend_pul_q;
                                dead_q     <= pend_dead_q;
                                pend_vld_q <= load_ok;
                                ack_dly_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign cfg_ack      = ack_q;
    assign cfg_err      = err_q;
    assign period_start = pstart_q;
    assign SWIPT_OUT0   = gate_q[0];
    assign SWIPT_OUT1   = gate_q[1];
    assign SWIPT_OUT2   = gate_q[2];
    assign SWIPT_OUT3   = gate_q[3];

endmodule

// File: tb/tb_swipt_bridge_pwm.sv
// Self-checking bench for swipt_bridge_pwm: a period-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed pulse counts, period lengths and handshake timing.
module tb_swipt_bridge_pwm;

    localparam int CNT_W   = 16;
    localparam int DT_W    = 6;
    localparam int PH_IDLE = 0;
    localparam int PH_POS  = 1;
    localparam int PH_NEG  = 2;

    logic             clk;
    logic             nrst;
    logic             en;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] pulse_in;
    logic [DT_W-1:0]  dead_in;
    logic             load;
    logic             cfg_ack;
    logic             cfg_err;
    logic             period_start;
    logic             SWIPT_OUT0;
    logic             SWIPT_OUT1;
    logic             SWIPT_OUT2;
    logic             SWIPT_OUT3;
    logic [3:0]       gates;

    int n_cmp  = 0;
    int n_fail = 0;

    swipt_bridge_pwm #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .period_in    (period_in),
        .pulse_in     (pulse_in),
        .dead_in      (dead_in),
        .load         (load),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err),
        .period_start (period_start),
        .SWIPT_OUT0   (SWIPT_OUT0),
        .SWIPT_OUT1   (SWIPT_OUT1),
        .SWIPT_OUT2   (SWIPT_OUT2),
        .SWIPT_OUT3   (SWIPT_OUT3)
    );

    assign gates = {SWIPT_OUT3, SWIPT_OUT2, SWIPT_OUT1, SWIPT_OUT0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Gate pattern {OUT3,OUT2,OUT1,OUT0} for position c of a half, straight from the region rules.
    function automatic logic [3:0] gate_of(input int ph, input int c, input int p, input int w, input int d);
        logic [3:0] g;
        int h;
        int e;
        g = 4'b1100;
        if (ph == PH_IDLE || w <= d) return g;
        h = (ph == PH_POS) ? p / 2 : p - p / 2;
        e = (h - d > 0) ? h - d : 0;
        if (w < e) e = w;
        if (c < e + d) begin
            if (ph == PH_POS) begin
                g[2] = 1'b0;
                g[0] = (c >= d && c < e);
            end else begin
                g[3] = 1'b0;
                g[1] = (c >= d && c < e);
            end
        end
        return g;
    endfunction

    int         m_ph, m_c, m_p, m_w, m_d;
    int         m_pp, m_pw, m_pd;
    bit         m_pend, m_ack_next;
    logic [3:0] exp_gate;
    logic       exp_ps, exp_ack, exp_err;

    // Model: tracks the bridge position and active settings; outputs show the position held before each edge.
    always @(posedge clk or negedge nrst) begin
        bit ok;
        int h;
        if (!nrst) begin
            m_ph = PH_IDLE; m_c = 0; m_p = 100; m_w = 0; m_d = 4;
            m_pp = 0; m_pw = 0; m_pd = 0; m_pend = 0; m_ack_next = 0;
            exp_gate = 4'b1100; exp_ps = 0; exp_ack = 0; exp_err = 0;
        end else begin
            ok = load && (int'(period_in) >= 4) && (int'(period_in) >= 2 * (2 * int'(dead_in) + 2));
            exp_gate   = gate_of(m_ph, m_c, m_p, m_w, m_d);
            exp_ps     = (m_ph == PH_POS && m_c == 0);
            exp_err    = load && !ok;
            exp_ack    = m_ack_next;
            m_ack_next = 0;
            h = (m_ph == PH_POS) ? m_p / 2 : m_p - m_p / 2;
            if (m_ph == PH_IDLE) begin
                if (m_pend) begin
                    m_p = m_pp; m_w = m_pw; m_d = m_pd; m_pend = 0; exp_ack = 1;
                end else if (ok) begin
                    m_p = int'(period_in); m_w = int'(pulse_in); m_d = int'(dead_in); exp_ack = 1; ok = 0;
                end
                if (en) begin m_ph = PH_POS; m_c = 0; end
            end else if (m_c == h - 1) begin
                m_c = 0;
                if (m_ph == PH_POS) m_ph = PH_NEG;
                else if (en) begin
                    m_ph = PH_POS;
                    if (m_pend) begin
                        m_p = m_pp; m_w = m_pw; m_d = m_pd; m_pend = 0; m_ack_next = 1;
                    end
                end else m_ph = PH_IDLE;
            end else begin
                m_c++;
            end
            if (ok) begin
                m_pend = 1; m_pp = int'(period_in); m_pw = int'(pulse_in); m_pd = int'(dead_in);
            end
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            check("gates", 32'(gates), 32'(exp_gate));
            check("period_start", 32'(period_start), 32'(exp_ps));
            check("cfg_ack", 32'(cfg_ack), 32'(exp_ack));
            check("cfg_err", 32'(cfg_err), 32'(exp_err));
            check("shoot_through", 32'((SWIPT_OUT0 & SWIPT_OUT2) | (SWIPT_OUT1 & SWIPT_OUT3)), 32'd0);
        end
    end

    task automatic do_load(input int p, input int w, input int d);
        period_in = CNT_W'(p);
        pulse_in  = CNT_W'(w);
        dead_in   = DT_W'(d);
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic wait_ps(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!period_start && cyc < limit);
        if (!period_start) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_ps: no period_start within %0d cycles", limit);
        end
    endtask

    task automatic measure(input int n, output int hi0, output int hi1, output int lo2, output int lo3, output int fall3);
        hi0 = 0; hi1 = 0; lo2 = 0; lo3 = 0; fall3 = -1;
        for (int i = 0; i < n; i++) begin
            if (SWIPT_OUT0) hi0++;
            if (SWIPT_OUT1) hi1++;
            if (!SWIPT_OUT2) lo2++;
            if (!SWIPT_OUT3) begin
                lo3++;
                if (fall3 < 0) fall3 = i;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hi0, hi1, lo2, lo3, fall3, i;
        nrst = 1'b0; en = 1'b0; load = 1'b0;
        period_in = '0; pulse_in = '0; dead_in = '0;

        repeat (3) @(negedge clk);
        check("reset_gates", 32'(gates), 32'hC);
        check("reset_ps", 32'(period_start), 32'd0);
        check("reset_ack", 32'(cfg_ack), 32'd0);
        check("reset_err", 32'(cfg_err), 32'd0);
        #2 nrst = 1'b1;

        repeat (4) @(negedge clk);
        check("idle_gates", 32'(gates), 32'hC);

        // Load in IDLE is acknowledged on the next cycle.
        do_load(100, 30, 4);
        check("idle_load_ack", 32'(cfg_ack), 32'd1);

        // Start latency: POS c=0 two edges after en is first sampled.
        en = 1'b1;
        @(negedge clk);
        check("start_ps_early", 32'(period_start), 32'd0);
        @(negedge clk);
        check("start_ps", 32'(period_start), 32'd1);
        measure(100, hi0, hi1, lo2, lo3, fall3);
        check("w30_out0_hi", 32'(hi0), 32'd26);
        check("w30_out2_lo", 32'(lo2), 32'd34);
        check("w30_out1_hi", 32'(hi1), 32'd26);
        check("w30_out3_lo", 32'(lo3), 32'd34);
        check("w30_neg_start", 32'(fall3), 32'd50);
        check("w30_period", 32'(period_start), 32'd1);

        // W=60: pulse clipped to H-D, no freewheel.
        do_load(100, 60, 4);
        wait_ps(300, cyc);
        check("w60_wait", 32'(cyc), 32'd99);
        check("w60_ack", 32'(cfg_ack), 32'd1);
        measure(100, hi0, hi1, lo2, lo3, fall3);
        check("w60_out0_hi", 32'(hi0), 32'd42);
        check("w60_out2_lo", 32'(lo2), 32'd50);
        check("w60_out3_lo", 32'(lo3), 32'd50);

        // W=3 <= D: whole period freewheels.
        do_load(100, 3, 4);
        wait_ps(300, cyc);
        check("w3_ack", 32'(cfg_ack), 32'd1);
        measure(100, hi0, hi1, lo2, lo3, fall3);
        check("w3_out0_hi", 32'(hi0), 32'd0);
        check("w3_out1_hi", 32'(hi1), 32'd0);
        check("w3_out2_lo", 32'(lo2), 32'd0);
        check("w3_out3_lo", 32'(lo3), 32'd0);

        // Reload mid-POS: old period completes, then 80-cycle periods.
        repeat (10) @(negedge clk);
        do_load(80, 20, 4);
        wait_ps(300, cyc);
        check("p80_wait", 32'(cyc), 32'd89);
        check("p80_ack", 32'(cfg_ack), 32'd1);
        measure(80, hi0, hi1, lo2, lo3, fall3);
        check("p80_out0_hi", 32'(hi0), 32'd16);
        check("p80_out1_hi", 32'(hi1), 32'd16);
        check("p80_period", 32'(period_start), 32'd1);

        // Rejected load.
        do_load(3, 5, 1);
        check("bad_err", 32'(cfg_err), 32'd1);
        check("bad_no_ack", 32'(cfg_ack), 32'd0);
        wait_ps(300, cyc);
        check("bad_period_kept", 32'(cyc), 32'd79);
        check("bad_no_late_ack", 32'(cfg_ack), 32'd0);

        // Odd period: NEG gets the extra cycle.
        do_load(101, 30, 4);
        wait_ps(300, cyc);
        check("p101_ack", 32'(cfg_ack), 32'd1);
        measure(101, hi0, hi1, lo2, lo3, fall3);
        check("p101_pos_len", 32'(fall3), 32'd50);
        check("p101_out0_hi", 32'(hi0), 32'd26);
        check("p101_out1_hi", 32'(hi1), 32'd26);
        check("p101_period", 32'(period_start), 32'd1);

        // en dropped at c=5: the period still completes, then IDLE.
        repeat (5) @(negedge clk);
        en = 1'b0;
        measure(96, hi0, hi1, lo2, lo3, fall3);
        check("endrop_neg_done", 32'(hi1), 32'd26);
        check("endrop_no_ps", 32'(period_start), 32'd0);
        check("endrop_idle", 32'(gates), 32'hC);
        repeat (10) @(negedge clk);
        check("endrop_idle_hold", 32'(gates), 32'hC);

        // Asynchronous reset during a high-side pulse.
        en = 1'b1;
        i = 0;
        while (!SWIPT_OUT0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("pulse_seen", 32'(SWIPT_OUT0), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_out0", 32'(SWIPT_OUT0), 32'd0);
        check("async_rst_gates", 32'(gates), 32'hC);
        @(negedge clk);
        en = 1'b0;
        #2 nrst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'(gates), 32'hC);
        check("post_rst_no_ps", 32'(period_start), 32'd0);
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_start", 32'(period_start), 32'd1);

        // Random stimulus; the model comparison and shoot-through monitor run every cycle.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) en = ~en;
            load      = ($urandom_range(0, 19) == 0);
            period_in = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 5)) : CNT_W'($urandom_range(4, 60));
            pulse_in  = CNT_W'($urandom_range(0, 40));
            dead_in   = DT_W'($urandom_range(0, 7));
        end
        @(negedge clk);
        load = 1'b0;
        en   = 1'b0;
        repeat (150) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
